// File: rtl/cache_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_arb_pkg                                                        |
// | Shared types and port identifiers for the cache port arbiter.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cache_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_IF  = 1'b0;
  localparam port_id_t PORT_MEM = 1'b1;

  function automatic port_id_t other_port(input port_id_t id);
    return ~id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_arb_rr2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_arb_rr2                                                        |
// | Two-way round-robin picker: on a tie the port that did not own the   |
// | last acceptance wins.                                                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cache_arb_rr2
  import cache_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last,
  output port_id_t   sel,
  output logic       any
);

  always_comb begin
    any = |req;
    if (&req) begin
      sel = other_port(last);
    end else begin
      sel = req[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_port_arbiter                                                   |
// | Shares one blocking data cache between the fetch and memory ports,   |
// | replaying a missed request from hold registers until it is accepted. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_req,
  input  logic              p0_wr_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wr_data,
  output logic              p0_ready,
  output logic              p0_stall,
  output logic              p0_rd_valid,
  output logic [DATA_W-1:0] p0_rd_data,
  input  logic              p1_rd_req,
  input  logic              p1_wr_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_ready,
  output logic              p1_stall,
  output logic              p1_rd_valid,
  output logic [DATA_W-1:0] p1_rd_data,
  output logic              c_rd_req,
  output logic              c_wr_req,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wr_data,
  input  logic              c_miss,
  input  logic [DATA_W-1:0] c_rd_data,
  output logic [CNT_W-1:0]  cnt_acc0,
  output logic [CNT_W-1:0]  cnt_acc1,
  output logic [CNT_W-1:0]  cnt_miss
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  port_id_t          r_last;
  port_id_t          r_lock_id;
  port_id_t          r_rd_id;
  logic              r_rd_pending;
  logic              r_hold_rd;
  logic              r_hold_wr;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;
  logic [CNT_W-1:0]  r_cnt_acc0;
  logic [CNT_W-1:0]  r_cnt_acc1;
  logic [CNT_W-1:0]  r_cnt_miss;

  logic [1:0]        w_rd;
  logic [1:0]        w_wr;
  logic [1:0]        w_req;
  logic [1:0]        w_ready;
  logic [1:0]        w_stall;
  logic [1:0]        w_rd_valid;
  port_id_t          w_sel;
  port_id_t          w_owner;
  logic              w_any;
  logic              w_c_rd;
  logic              w_c_wr;
  logic [ADDR_W-1:0] w_c_addr;
  logic [DATA_W-1:0] w_c_data;
  logic              w_accept;
  logic              w_miss_evt;

  assign w_rd  = {p1_rd_req, p0_rd_req};
  assign w_wr  = {p1_wr_req, p0_wr_req};
  assign w_req = w_rd | w_wr;

  cache_arb_rr2 u_rr2 (
    .req  (w_req),
    .last (r_last),
    .sel  (w_sel),
    .any  (w_any)
  );

  // Cache drive is kept apart from c_miss so no loop forms through the cache.
  always_comb begin : p_drive
    w_owner  = w_sel;
    w_c_rd   = 1'b0;
    w_c_wr   = 1'b0;
    w_c_addr = (w_sel == PORT_MEM) ? p1_addr    : p0_addr;
    w_c_data = (w_sel == PORT_MEM) ? p1_wr_data : p0_wr_data;
    if (r_state == ARB_LOCKED) begin
      w_owner  = r_lock_id;
      w_c_rd   = r_hold_rd;
      w_c_wr   = r_hold_wr;
      w_c_addr = r_hold_addr;
      w_c_data = r_hold_data;
    end else if (w_any) begin
      w_c_wr = w_wr[w_sel];
      w_c_rd = w_rd[w_sel] & ~w_wr[w_sel];
    end
    if (rst) begin
      w_c_rd = 1'b0;
      w_c_wr = 1'b0;
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_miss_evt  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_c_rd | w_c_wr) begin
          if (c_miss) begin
            w_miss_evt  = 1'b1;
            w_state_nxt = ARB_LOCKED;
          end else begin
            w_accept = 1'b1;
          end
        end
      end
      ARB_LOCKED: begin
        if (!c_miss) begin
          w_accept    = 1'b1;
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  for (genvar g = 0; g < 2; g++) begin : g_port
    // The locked owner stays stalled even if it withdrew its request.
    assign w_ready[g]    = w_accept && (w_owner == port_id_t'(g));
    assign w_stall[g]    = (r_state == ARB_LOCKED && r_lock_id == port_id_t'(g)) ?
                           !w_accept : (w_req[g] && !w_ready[g] && !rst);
    assign w_rd_valid[g] = r_rd_pending && (r_rd_id == port_id_t'(g));
  end

  always_ff @(posedge clk or posedge rst) begin : p_state
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin : p_regs
    if (rst) begin
      r_last       <= PORT_MEM;
      r_lock_id    <= PORT_IF;
      r_rd_id      <= PORT_IF;
      r_rd_pending <= 1'b0;
      r_hold_rd    <= 1'b0;
      r_hold_wr    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
      r_cnt_acc0   <= '0;
      r_cnt_acc1   <= '0;
      r_cnt_miss   <= '0;
    end else begin
      r_rd_pending <= w_accept & w_c_rd;
      if (w_miss_evt) begin
        r_hold_rd   <= w_c_rd;
        r_hold_wr   <= w_c_wr;
        r_hold_addr <= w_c_addr;
        r_hold_data <= w_c_data;
        r_lock_id   <= w_owner;
        r_cnt_miss  <= r_cnt_miss + CNT_W'(1);
      end
      if (w_accept) begin
        r_last <= w_owner;
        if (w_c_rd) begin
          r_rd_id <= w_owner;
        end
        if (w_owner == PORT_IF) begin
          r_cnt_acc0 <= r_cnt_acc0 + CNT_W'(1);
        end else begin
          r_cnt_acc1 <= r_cnt_acc1 + CNT_W'(1);
        end
      end
    end
  end

  assign c_rd_req    = w_c_rd;
  assign c_wr_req    = w_c_wr;
  assign c_addr      = w_c_addr;
  assign c_wr_data   = w_c_data;
  assign p0_ready    = w_ready[PORT_IF];
  assign p1_ready    = w_ready[PORT_MEM];
  assign p0_stall    = w_stall[PORT_IF];
  assign p1_stall    = w_stall[PORT_MEM];
  assign p0_rd_valid = w_rd_valid[PORT_IF];
  assign p1_rd_valid = w_rd_valid[PORT_MEM];
  assign p0_rd_data  = c_rd_data;
  assign p1_rd_data  = c_rd_data;
  assign cnt_acc0    = r_cnt_acc0;
  assign cnt_acc1    = r_cnt_acc1;
  assign cnt_miss    = r_cnt_miss;

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cache_port_arbiter                                                |
// | Directed bench with a small blocking-cache model (3 miss cycles).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_rd_req = 1'b0, p0_wr_req = 1'b0;
  logic [31:0] p0_addr = '0, p0_wr_data = '0;
  logic        p0_ready, p0_stall, p0_rd_valid;
  logic [31:0] p0_rd_data;
  logic        p1_rd_req = 1'b0, p1_wr_req = 1'b0;
  logic [31:0] p1_addr = '0, p1_wr_data = '0;
  logic        p1_ready, p1_stall, p1_rd_valid;
  logic [31:0] p1_rd_data;
  logic        c_rd_req, c_wr_req, c_miss;
  logic [31:0] c_addr, c_wr_data, c_rd_data;
  logic [31:0] cnt_acc0, cnt_acc1, cnt_miss;

  int n_cmp = 0;
  int n_bad = 0;

  // Cache model state
  logic [31:0] mem [8];
  logic [7:0]  line_valid;
  logic [1:0]  refill;
  logic [31:0] rd_q;
  logic        clr_mem = 1'b1;
  logic        inval   = 1'b0;
  logic        p1_done = 1'b0;

  always #5 clk = ~clk;

  cache_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_ready(p0_ready), .p0_stall(p0_stall), .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_ready(p1_ready), .p1_stall(p1_stall), .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_addr(c_addr), .c_wr_data(c_wr_data),
    .c_miss(c_miss), .c_rd_data(c_rd_data),
    .cnt_acc0(cnt_acc0), .cnt_acc1(cnt_acc1), .cnt_miss(cnt_miss)
  );

  assign c_miss    = (c_rd_req | c_wr_req) && !line_valid[c_addr[4:2]];
  assign c_rd_data = rd_q;

  // First touch of a line misses for three cycles, then hits.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      line_valid <= '0;
      refill     <= '0;
      rd_q       <= '0;
      if (clr_mem) for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else if (inval) begin
      line_valid <= '0;
    end else if (c_rd_req | c_wr_req) begin
      if (c_miss) begin
        if (refill == 2'd2) begin
          line_valid[c_addr[4:2]] <= 1'b1;
          refill <= '0;
        end else begin
          refill <= refill + 2'd1;
        end
      end else if (c_wr_req) begin
        mem[c_addr[4:2]] <= c_wr_data;
      end else begin
        rd_q <= mem[c_addr[4:2]];
      end
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One port-1 access: present, wait for ready, then idle a cycle and check read return.
  task automatic p1_op(input logic wr, input logic [31:0] addr, input logic [31:0] val,
                       input string tag);
    int n;
    @(posedge clk); #1;
    p1_wr_req  = wr;
    p1_rd_req  = !wr;
    p1_addr    = addr;
    p1_wr_data = wr ? val : 32'h0;
    n = 0;
    @(negedge clk);
    while (!p1_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_value({tag, "_rdy"}, {31'b0, p1_ready}, 32'd1);
    @(posedge clk); #1;
    p1_wr_req = 1'b0;
    p1_rd_req = 1'b0;
    @(negedge clk);
    if (!wr) begin
      check_value({tag, "_vld"}, {31'b0, p1_rd_valid}, 32'd1);
      check_value({tag, "_dat"}, p1_rd_data, val);
    end
  endtask

  // {wr, addr, data/expected}
  logic [19:0] ops [32] = '{
    20'h1_00_03, 20'h1_04_11, 20'h0_00_03, 20'h1_08_0c, 20'h1_0c_07, 20'h0_04_11,
    20'h1_10_0b, 20'h1_14_09, 20'h0_08_0c, 20'h1_18_08, 20'h1_1c_01, 20'h0_0c_07,
    20'h1_00_0c, 20'h0_10_0b, 20'h1_0c_05, 20'h0_14_09, 20'h1_14_00, 20'h0_18_08,
    20'h1_1c_05, 20'h0_1c_05, 20'h0_00_0c, 20'h0_0c_05, 20'h0_14_00, 20'h1_04_02,
    20'h0_04_02, 20'h1_04_11, 20'h0_04_11, 20'h0_08_0c, 20'h1_10_0b, 20'h0_10_0b,
    20'h0_18_08, 20'h0_1c_05
  };
  logic [7:0] final_exp [8] = '{8'h0c, 8'h11, 8'h0c, 8'h05, 8'h0b, 8'h00, 8'h08, 8'h05};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_c_rd", {31'b0, c_rd_req}, 32'd0);
    check_value("rst_c_wr", {31'b0, c_wr_req}, 32'd0);
    check_value("rst_rdy", {30'b0, p1_ready, p0_ready}, 32'd0);
    check_value("rst_stall", {30'b0, p1_stall, p0_stall}, 32'd0);
    check_value("rst_vld", {30'b0, p1_rd_valid, p0_rd_valid}, 32'd0);
    check_value("rst_acc0", cnt_acc0, 32'd0);
    check_value("rst_acc1", cnt_acc1, 32'd0);
    check_value("rst_miss", cnt_miss, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clr_mem = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_value($sformatf("idle%0d", i), {30'b0, c_rd_req, c_wr_req}, 32'd0);
    end

    // Port 1 write miss then read hit
    @(posedge clk); #1;
    p1_wr_req = 1'b1; p1_addr = 32'h0; p1_wr_data = 32'h1b;
    @(negedge clk);
    check_value("wm_c_wr", {31'b0, c_wr_req}, 32'd1);
    check_value("wm_stall0", {31'b0, p1_stall}, 32'd1);
    check_value("wm_rdy0", {31'b0, p1_ready}, 32'd0);
    @(negedge clk);
    check_value("wm_stall1", {31'b0, p1_stall}, 32'd1);
    check_value("wm_cnt_miss", cnt_miss, 32'd1);
    @(negedge clk);
    check_value("wm_stall2", {31'b0, p1_stall}, 32'd1);
    @(negedge clk);
    check_value("wm_rdy3", {31'b0, p1_ready}, 32'd1);
    check_value("wm_stall3", {31'b0, p1_stall}, 32'd0);
    @(posedge clk); #1;
    p1_wr_req = 1'b0; p1_rd_req = 1'b1;
    @(negedge clk);
    check_value("rh_rdy", {31'b0, p1_ready}, 32'd1);
    @(posedge clk); #1;
    p1_rd_req = 1'b0;
    @(negedge clk);
    check_value("rh_vld", {30'b0, p1_rd_valid, p0_rd_valid}, 32'd2);
    check_value("rh_dat", p1_rd_data, 32'h1b);
    @(negedge clk);
    check_value("rh_vld_off", {31'b0, p1_rd_valid}, 32'd0);
    check_value("rh_acc1", cnt_acc1, 32'd2);

    // Simultaneous reads alternate
    p1_op(1'b1, 32'h08, 32'h11, "pre8");
    p1_op(1'b1, 32'h1c, 32'h22, "pre1c");
    @(posedge clk); #1;
    p0_rd_req = 1'b1; p0_addr = 32'h08;
    p1_rd_req = 1'b1; p1_addr = 32'h1c;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_value($sformatf("alt%0d_rdy0", k), {31'b0, p0_ready}, {31'b0, (k == 0 || k == 2)});
      check_value($sformatf("alt%0d_rdy1", k), {31'b0, p1_ready}, {31'b0, (k == 1 || k == 3)});
      check_value($sformatf("alt%0d_vld0", k), {31'b0, p0_rd_valid}, {31'b0, (k == 1 || k == 3)});
      check_value($sformatf("alt%0d_vld1", k), {31'b0, p1_rd_valid}, {31'b0, (k == 2 || k == 4)});
      if (k == 1 || k == 3) check_value($sformatf("alt%0d_dat0", k), p0_rd_data, 32'h11);
      if (k == 2 || k == 4) check_value($sformatf("alt%0d_dat1", k), p1_rd_data, 32'h22);
      @(posedge clk); #1;
      if (k == 3) begin
        p0_rd_req = 1'b0;
        p1_rd_req = 1'b0;
      end
    end

    // Port 0 misses on 0x10 while port 1 keeps requesting; port 0 drops mid-miss
    p0_rd_req = 1'b1; p0_addr = 32'h10;
    p1_rd_req = 1'b1; p1_addr = 32'h1c;
    @(negedge clk);
    check_value("lk0_addr", c_addr, 32'h10);
    check_value("lk0_stall", {30'b0, p1_stall, p0_stall}, 32'd3);
    @(posedge clk); #1;
    p0_rd_req = 1'b0;
    @(negedge clk);
    check_value("lk1_addr", c_addr, 32'h10);
    check_value("lk1_c_rd", {31'b0, c_rd_req}, 32'd1);
    check_value("lk1_stall", {30'b0, p1_stall, p0_stall}, 32'd3);
    check_value("lk1_miss", cnt_miss, 32'd4);
    @(negedge clk);
    check_value("lk2_addr", c_addr, 32'h10);
    @(negedge clk);
    check_value("lk3_rdy", {30'b0, p1_ready, p0_ready}, 32'd1);
    check_value("lk3_addr", c_addr, 32'h10);
    @(negedge clk);
    check_value("lk4_rdy", {30'b0, p1_ready, p0_ready}, 32'd2);
    check_value("lk4_addr", c_addr, 32'h1c);
    check_value("lk4_vld0", {31'b0, p0_rd_valid}, 32'd1);
    check_value("lk4_dat0", p0_rd_data, 32'h0);
    @(posedge clk); #1;
    p1_rd_req = 1'b0;
    @(negedge clk);
    check_value("lk5_vld", {30'b0, p1_rd_valid, p0_rd_valid}, 32'd2);
    check_value("lk5_dat1", p1_rd_data, 32'h22);
    check_value("lk5_acc0", cnt_acc0, 32'd3);
    check_value("lk5_acc1", cnt_acc1, 32'd7);

    // 32-op port-1 sequence with random port-0 fetch contention
    fork
      begin
        for (int i = 0; i < 32; i++)
          p1_op(ops[i][16], {24'h0, ops[i][15:8]}, {24'h0, ops[i][7:0]}, $sformatf("seq%0d", i));
        p1_done = 1'b1;
      end
      begin
        while (!p1_done) begin
          @(posedge clk); #1;
          if ($urandom_range(0, 2) == 0 && !p1_done) begin
            p0_rd_req = 1'b1;
            p0_addr   = 32'($urandom_range(0, 7)) << 2;
            n0 = 0;
            @(negedge clk);
            while (!p0_ready && n0 < 40) begin
              @(negedge clk);
              n0++;
            end
            check_value("cont_rdy0", {31'b0, p0_ready}, 32'd1);
            @(posedge clk); #1;
            p0_rd_req = 1'b0;
          end
        end
      end
    join
    check_value("seq_acc1", cnt_acc1, 32'd39);
    for (int i = 0; i < 8; i++)
      p1_op(1'b0, 32'(i * 4), {24'h0, final_exp[i]}, $sformatf("final%0d", i));
    check_value("final_acc1", cnt_acc1, 32'd47);

    // Reset while a miss is locked
    @(posedge clk); #1;
    inval = 1'b1;
    @(posedge clk); #1;
    inval = 1'b0;
    p0_rd_req = 1'b1; p0_addr = 32'h0;
    @(negedge clk);
    check_value("rl_stall0", {31'b0, p0_stall}, 32'd1);
    @(negedge clk);
    check_value("rl_locked_stall", {31'b0, p0_stall}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_value("rl_c_rd", {31'b0, c_rd_req}, 32'd0);
    check_value("rl_stall", {30'b0, p1_stall, p0_stall}, 32'd0);
    check_value("rl_rdy", {30'b0, p1_ready, p0_ready}, 32'd0);
    check_value("rl_acc0", cnt_acc0, 32'd0);
    check_value("rl_acc1", cnt_acc1, 32'd0);
    check_value("rl_miss", cnt_miss, 32'd0);
    p0_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_value("pr_idle", {30'b0, c_rd_req, c_wr_req}, 32'd0);
    p1_op(1'b0, 32'h04, 32'h11, "post_rst");
    check_value("pr_acc1", cnt_acc1, 32'd1);
    check_value("pr_miss", cnt_miss, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Two-requester arbiter that shares one blocking data cache (the `cache` block with `miss`, `rd_req`/`wr_req`, `addr`, `wr_data` and `rd_data`) between the instruction-fetch port (port 0) and the memory-stage port (port 1) of the RV32I core.
- Arbitration is round-robin.
- On a miss, the granted request is latched and replayed, so the cache inputs stay stable for the whole refill/writeback.
- Read data returns to the owning port one cycle after acceptance; the other port is stalled.
- Per-port access counters and a miss counter are kept for performance analysis.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- pN_rd_req  in  1  port N (N=0,1) read request, held until pN_ready
- pN_wr_req  in  1  port N write request; if asserted together with rd, write wins and rd is ignored
- pN_addr  in  ADDR_W  port N word address
- pN_wr_data  in  DATA_W  port N write data
- pN_ready  out  1  port N request accepted this cycle (combinational)
- pN_stall  out  1  pN request pending and not ready (combinational)
- pN_rd_valid  out  1  pN read data valid this cycle (registered)
- pN_rd_data  out  DATA_W  equals c_rd_data (shared, qualified by pN_rd_valid)
- c_rd_req, c_wr_req  out  1  cache requests
- c_addr  out  ADDR_W  cache address
- c_wr_data  out  DATA_W  cache write data
- c_miss  in  1  cache busy/miss (combinational from cache)
- c_rd_data  in  DATA_W  cache read data, valid the cycle after acceptance
- cnt_acc0, cnt_acc1, cnt_miss  out  CNT_W  accepted-access and miss-event counters

## Operation
- Acceptance: a cycle in which c_rd_req|c_wr_req is high and c_miss is low; the access commits at that posedge.
- States:
  - ARB_IDLE: the selected port is the round-robin pick among requesting ports; priority goes to the port not equal to `last`. If only one port requests, it is picked. The cache is driven combinationally from the selected port.
  - ARB_LOCKED: the cache is driven from the hold registers (`hold_rd`, `hold_wr`, `hold_addr`, `hold_data`, `lock_id`). Port `lock_id` sees pN_stall=1; the other port sees its request stalled.
- Transitions:
  - IDLE→LOCKED when a selected request sees c_miss=1. The request is latched into the hold registers and cnt_miss is incremented.
  - LOCKED→IDLE at the acceptance edge, when c_miss falls while the hold is driven.
  - IDLE→IDLE on acceptance with no miss.
- At every acceptance:
  - `last` ← owner.
  - cnt_accN increments for the owning port.
  - If the access was a read, rd_pending ← 1 and rd_id ← owner.
- pN_rd_valid = rd_pending && rd_id==N, for exactly one cycle.
- pN_ready is high in the acceptance cycle of port N's request, including the final cycle of a locked replay. The port may change or drop its request in the next cycle.
- A port dropping its request while LOCKED is ignored; the replay completes, and the result is still delivered if it was a read.
- Counters wrap modulo 2^CNT_W.
- Reset values:
  - state=ARB_IDLE, last=1 (port 0 wins the first tie), rd_pending=0.
  - All counters 0; hold registers 0.
  - All c_* request outputs 0; all pN_ready, pN_stall and pN_rd_valid outputs 0.
- Reset mid-miss abandons the replay immediately; the cache is expected to be reset by the same rst.

## Timing
- Hit latency: request in cycle t with c_miss=0 → pN_ready in cycle t, pN_rd_valid and data in cycle t+1.
- Back-to-back: the owner may present a new request in t+1. The other port, if waiting, wins t+1 by round-robin.
- Miss latency: the request is latched at the end of cycle t. Cache inputs remain at the hold values until the first cycle with c_miss=0 (cycle m), where pN_ready=1. Data arrives in m+1.
- Simultaneous requests: exactly one is selected per cycle, alternating across consecutive acceptances.
- Combinational paths exist from pN_*req and c_miss to c_* and pN_ready; there is no path from c_rd_data to any control signal.

## Structure
- Package cache_arb_pkg: typedef enum {ARB_IDLE, ARB_LOCKED} arb_state_t; typedef logic port_id_t; constants PORT_IF=0, PORT_MEM=1.
- One sub-module, cache_arb_rr2: a 2-way round-robin picker (inputs req[1:0] and last; outputs sel and any).
- The top level holds the FSM, hold registers, read-return tracking and counters.

## Test plan
- Reset then idle: all outputs 0 and counters 0; c_rd_req=c_wr_req=0 for 10 cycles.
- Port 1 writes 0x1b to 0x0, then reads 0x0:
  - The first access misses: cnt_miss=1 and p1_stall stays high until c_miss falls.
  - The read returns p1_rd_data=0x0000001b with a single-cycle p1_rd_valid.
- Both ports request reads (0x8 and 0x1c) in the same cycle after reset:
  - Port 0 is accepted first, port 1 next.
  - Exactly one pN_rd_valid is high per cycle, with correct data for each port.
- Port 0 misses on 0x10 while port 1 requests continuously:
  - c_addr stays 0x10 through the miss, even if p0 drops its request mid-miss.
  - Port 1 is accepted only after LOCKED→IDLE.
- Contention and end-of-run readback:
  - Replay the 32 write/read cycle sequence on port 1 with random port-0 fetch contention.
  - Final sequential reads of 0x0–0x1c return 0c 11 0c 05 0b 00 08 05.
  - cnt_acc1 equals the number of port-1 operations.
- Assert rst during a locked miss: state returns to IDLE and counters and outputs clear asynchronously. After release, a read of 0x4 completes normally.
